// File: rtl/aes_inv_key_sched_if.sv
// Key-load and round-key stream bundle for the inverse AES-128 key schedule.
interface aes_inv_key_sched_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  modport master (output key_in, key_valid, rk_ready,
                  input  key_ready, rk_out, rk_round, rk_valid, busy);
  modport slave  (input  key_in, key_valid, rk_ready,
                  output key_ready, rk_out, rk_round, rk_valid, busy);
endinterface

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: takes round key NR and streams round keys NR..0,
// one full 128-bit key per step, optionally with a registered SubWord stage.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  function automatic logic [7:0] f_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 via a short square/multiply chain; 0 maps to 0.
  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;
  assign w_x2   = f_mul(i_a, i_a);
  assign w_x3   = f_mul(w_x2, i_a);
  assign w_x6   = f_mul(w_x3, w_x3);
  assign w_x12  = f_mul(w_x6, w_x6);
  assign w_x15  = f_mul(w_x12, w_x3);
  assign w_x30  = f_mul(w_x15, w_x15);
  assign w_x60  = f_mul(w_x30, w_x30);
  assign w_x120 = f_mul(w_x60, w_x60);
  assign w_x240 = f_mul(w_x120, w_x120);
  assign w_x252 = f_mul(w_x240, w_x12);
  assign w_inv  = f_mul(w_x252, w_x2);

  assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_sched #(
  parameter int NR        = 10,
  parameter int SBOX_PIPE = 0
) (
  input logic                clk,
  input logic                rst,
  aes_inv_key_sched_if.slave io
);
  localparam logic [3:0] LP_NR = 4'(NR);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OUT = 2'd1, S_CALC = 2'd2} state_t;

  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_valid, r_kready, r_busy;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot, w_sub, w_sub_use;
  logic [7:0]   w_rcon;
  logic [127:0] w_prev;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
  end

  // The key is stable through OUT and CALC, so the SubWord register can load every cycle.
  if (SBOX_PIPE != 0) begin : g_pipe
    logic [31:0] r_sub;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sub <= '0;
      else     r_sub <= w_sub;
    end
    assign w_sub_use = r_sub;
  end else begin : g_comb
    assign w_sub_use = w_sub;
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd10:   w_rcon = 8'h36;
      4'd9:    w_rcon = 8'h1b;
      4'd8:    w_rcon = 8'h80;
      4'd7:    w_rcon = 8'h40;
      4'd6:    w_rcon = 8'h20;
      4'd5:    w_rcon = 8'h10;
      4'd4:    w_rcon = 8'h08;
      4'd3:    w_rcon = 8'h04;
      4'd2:    w_rcon = 8'h02;
      4'd1:    w_rcon = 8'h01;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_p0   = w_w0 ^ w_sub_use ^ {w_rcon, 24'h0};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_round  <= '0;
      r_valid  <= 1'b0;
      r_kready <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io.key_valid) begin
          r_key    <= io.key_in;
          r_round  <= LP_NR;
          r_valid  <= 1'b1;
          r_kready <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= S_OUT;
        end
        S_OUT: if (io.rk_ready) begin
          if (r_round == 4'd0) begin
            r_valid  <= 1'b0;
            r_kready <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (SBOX_PIPE == 0) begin
            r_key   <= w_prev;
            r_round <= r_round - 4'd1;
          end else begin
            r_valid <= 1'b0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_key   <= w_prev;
          r_round <= r_round - 4'd1;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.key_ready = r_kready;
  assign io.rk_out    = r_key;
  assign io.rk_round  = r_round;
  assign io.rk_valid  = r_valid;
  assign io.busy      = r_busy;
endmodule
